// File: rtl/button_debouncer_pkg.sv
// ----------------------------------------------------------------------------
// button_debouncer_pkg
//
// Shared definitions for the push-button conditioning path: the debouncer FSM
// state encoding and the default timing constants for a 12 MHz system clock.
// Imported by button_debouncer and by anything that needs to interpret its
// state or reuse its default timing.
//
// Contents:
//   db_state_t             - 2-bit FSM state encoding
//   CLOCK_HZ               - nominal system clock frequency
//   DEFAULT_STABLE_CYCLES  - 1 ms qualification window at 12 MHz
//   DEFAULT_HOLD_CYCLES    - 0.5 s long-hold threshold at 12 MHz
//   cycles_from_us()       - converts a microsecond time to clock cycles
// ----------------------------------------------------------------------------
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } db_state_t;

  localparam int unsigned CLOCK_HZ              = 12_000_000;
  localparam int unsigned DEFAULT_STABLE_CYCLES = 12_000;
  localparam int unsigned DEFAULT_HOLD_CYCLES   = 6_000_000;

  // Integer cycle count for a time given in microseconds at CLOCK_HZ.
  function automatic int unsigned cycles_from_us(input int unsigned us);
    return (CLOCK_HZ / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
//
// Generic two-flop synchroniser for bringing asynchronous sensor and button
// lines into the clk domain. Both stages load RESET_VALUE while rst is low so
// that downstream logic sees a known idle level straight out of reset.
//
// Parameters:
//   WIDTH        - number of independent single-bit lines synchronised
//   RESET_VALUE  - level both stages take during reset
//
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-low reset
//   d    in   asynchronous input lines
//   q    out  synchronised lines (two clk edges of latency)
// ----------------------------------------------------------------------------
module sync_2ff #(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First stage may go metastable; the second stage gives it a full cycle to
  // resolve before anything downstream looks at it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// ----------------------------------------------------------------------------
// button_debouncer
//
// Conditions a raw, bouncy push-button pin into a clean debounced level plus
// single-cycle press, release and long-hold pulses. The pin is optionally
// inverted, synchronised by two flops, then qualified by a four-state FSM:
// a new level must be seen for STABLE_CYCLES consecutive synchronised samples
// before it is accepted. A separate hold counter fires b_hold once per press
// after HOLD_CYCLES cycles in the pressed state.
//
// Parameters:
//   STABLE_CYCLES  - samples a new level must persist (2 .. 2**20)
//   HOLD_CYCLES    - pressed cycles before b_hold (> STABLE_CYCLES)
//   INVERT         - 1 when the pin is active-low
//
// Ports:
//   clk        in   system clock (12 MHz)
//   rst        in   synchronous active-low reset
//   b_in       in   raw asynchronous button pin
//   b_state    out  debounced level, 1 = pressed
//   b_press    out  one-cycle pulse on accepted press
//   b_release  out  one-cycle pulse on accepted release
//   b_hold     out  one-cycle pulse once per press after HOLD_CYCLES
// ----------------------------------------------------------------------------
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int unsigned HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
  parameter bit          INVERT        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic b_in,
  output logic b_state,
  output logic b_press,
  output logic b_release,
  output logic b_hold
);

  localparam int CNT_W  = $clog2(STABLE_CYCLES);
  localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);
  localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(HOLD_CYCLES);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HOLD_CYCLES - 1);

  logic              pin_level;
  logic              s;
  db_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [HCNT_W-1:0] hcnt;

  // Inversion happens before the synchroniser so the FSM always works in
  // "1 = pressed" terms and the synchroniser's reset value of 0 is idle.
  assign pin_level = b_in ^ INVERT;

  sync_2ff #(
    .WIDTH       (1),
    .RESET_VALUE (1'b0)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pin_level),
    .q   (s)
  );

  // Qualification FSM with registered outputs. Entering a WAIT state loads
  // cnt with 1 because the sample that caused the transition already counts
  // towards the stable window, so the level is accepted on its
  // STABLE_CYCLES-th consecutive sample. cnt is cleared on every other state
  // change and can never pass STABLE_CYCLES-1, so it never wraps.
  // hcnt only advances while settled in PRESSED; it keeps its value across a
  // rejected release glitch and saturates at HOLD_CYCLES, which is what keeps
  // b_hold to a single pulse per press.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hcnt      <= '0;
      b_state   <= 1'b0;
      b_press   <= 1'b0;
      b_release <= 1'b0;
      b_hold    <= 1'b0;
    end else begin
      b_press   <= 1'b0;
      b_release <= 1'b0;
      b_hold    <= 1'b0;

      case (state)
        IDLE: begin
          if (s) begin
            state <= PRESS_WAIT;
            cnt   <= CNT_ONE;
          end else begin
            cnt   <= '0;
          end
        end

        PRESS_WAIT: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= PRESSED;
            cnt     <= '0;
            hcnt    <= '0;
            b_press <= 1'b1;
            b_state <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        PRESSED: begin
          if (!s) begin
            state <= RELEASE_WAIT;
            cnt   <= CNT_ONE;
          end else if (hcnt != HCNT_MAX) begin
            hcnt   <= hcnt + HCNT_ONE;
            b_hold <= (hcnt == HCNT_LAST);
          end
        end

        RELEASE_WAIT: begin
          if (s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            b_release <= 1'b1;
            b_state   <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// ----------------------------------------------------------------------------
// tb_button_debouncer
//
// Self-checking bench for button_debouncer with STABLE_CYCLES=8 and
// HOLD_CYCLES=40. Two instances run side by side: one with INVERT=0 driven by
// the pin level, one with INVERT=1 driven by the complemented pin, so every
// scenario also exercises the inverted configuration with identical timing.
// Stimulus pushes expected pulses (kind and edge number) into a queue per
// instance; a monitor pops and compares whenever an instance emits a pulse.
// ----------------------------------------------------------------------------
module tb_button_debouncer;

  localparam int unsigned STABLE = 8;
  localparam int unsigned HOLD   = 40;
  localparam int          LAT    = STABLE + 1;

  typedef enum logic [1:0] {
    EV_PRESS   = 2'd0,
    EV_RELEASE = 2'd1,
    EV_HOLD    = 2'd2
  } ev_kind_t;

  typedef struct {
    ev_kind_t kind;
    int       at_edge;
  } ev_t;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic b_in  = 1'b0;
  logic b_in_n = 1'b1;

  logic st0, p0, r0, h0;
  logic st1, p1, r1, h1;

  int  edge_n   = 0;
  int  n_checks = 0;
  int  n_errors = 0;
  ev_t exp_q0[$];
  ev_t exp_q1[$];

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  button_debouncer #(
    .STABLE_CYCLES (STABLE),
    .HOLD_CYCLES   (HOLD),
    .INVERT        (1'b0)
  ) dut_plain (
    .clk       (clk),
    .rst       (rst),
    .b_in      (b_in),
    .b_state   (st0),
    .b_press   (p0),
    .b_release (r0),
    .b_hold    (h0)
  );

  button_debouncer #(
    .STABLE_CYCLES (STABLE),
    .HOLD_CYCLES   (HOLD),
    .INVERT        (1'b1)
  ) dut_inv (
    .clk       (clk),
    .rst       (rst),
    .b_in      (b_in_n),
    .b_state   (st1),
    .b_press   (p1),
    .b_release (r1),
    .b_hold    (h1)
  );

  // Single point where every comparison is counted and reported.
  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edge_n);
    end
  endtask

  // Pops the next expected event for one instance whenever it pulses.
  task automatic monitor_dut(input int idx, input logic st, input logic p,
                             input logic r, input logic h);
    int       pulses;
    ev_kind_t kind;
    ev_t      e;
    int       have;
    if (p === 1'b1 || r === 1'b1 || h === 1'b1) begin
      pulses = int'(p === 1'b1) + int'(r === 1'b1) + int'(h === 1'b1);
      check_output($sformatf("dut%0d single_pulse", idx), pulses, 1);
      kind = (p === 1'b1) ? EV_PRESS : ((r === 1'b1) ? EV_RELEASE : EV_HOLD);
      have = (idx == 0) ? exp_q0.size() : exp_q1.size();
      if (have == 0) begin
        check_output($sformatf("dut%0d unexpected_pulse_kind", idx), int'(kind), -1);
      end else begin
        if (idx == 0) e = exp_q0.pop_front();
        else          e = exp_q1.pop_front();
        check_output($sformatf("dut%0d pulse_kind", idx), int'(kind), int'(e.kind));
        check_output($sformatf("dut%0d pulse_edge", idx), edge_n, e.at_edge);
        check_output($sformatf("dut%0d state_with_pulse", idx), int'(st),
                     (e.kind == EV_RELEASE) ? 0 : 1);
      end
    end
  endtask

  always @(negedge clk) begin
    monitor_dut(0, st0, p0, r0, h0);
    monitor_dut(1, st1, p1, r1, h1);
  end

  task automatic expect_event(input ev_kind_t kind, input int at_edge);
    ev_t e;
    e.kind    = kind;
    e.at_edge = at_edge;
    exp_q0.push_back(e);
    exp_q1.push_back(e);
  endtask

  // Drives the pin (called at a falling edge) and reports the first rising
  // edge that will sample the new level.
  task automatic apply_stimulus(input logic level, output int first_edge);
    first_edge = edge_n + 1;
    b_in       = level;
    b_in_n     = ~level;
  endtask

  task automatic hold_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_state(input string name, input int expected);
    check_output({"dut0 ", name}, int'(st0), expected);
    check_output({"dut1 ", name}, int'(st1), expected);
  endtask

  task automatic check_idle_outputs(input string name);
    check_output({"dut0 ", name, " b_state"}, int'(st0), 0);
    check_output({"dut0 ", name, " b_press"}, int'(p0), 0);
    check_output({"dut0 ", name, " b_release"}, int'(r0), 0);
    check_output({"dut0 ", name, " b_hold"}, int'(h0), 0);
    check_output({"dut1 ", name, " b_state"}, int'(st1), 0);
    check_output({"dut1 ", name, " b_press"}, int'(p1), 0);
    check_output({"dut1 ", name, " b_release"}, int'(r1), 0);
    check_output({"dut1 ", name, " b_hold"}, int'(h1), 0);
  endtask

  task automatic check_drained(input string name);
    check_output({"dut0 ", name, " missing_pulses"}, exp_q0.size(), 0);
    check_output({"dut1 ", name, " missing_pulses"}, exp_q1.size(), 0);
    exp_q0.delete();
    exp_q1.delete();
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int k;
    int bounce_high[3];
    bounce_high = '{3, 5, 7};

    // Reset state.
    hold_cycles(3);
    check_idle_outputs("reset");
    rst = 1'b1;
    hold_cycles(3);

    // Clean press and release, 20 cycles each; no hold.
    $display("[TB] clean press/release");
    apply_stimulus(1'b1, k);
    expect_event(EV_PRESS, k + LAT);
    hold_cycles(20);
    check_state("clean_pressed", 1);
    apply_stimulus(1'b0, k);
    expect_event(EV_RELEASE, k + LAT);
    hold_cycles(20);
    check_state("clean_released", 0);
    check_drained("clean");

    // Bouncing press: short highs rejected, final stable high accepted.
    // Then 7-cycle release glitches inside the press are rejected.
    $display("[TB] bounce rejection");
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, k);
      hold_cycles(bounce_high[i]);
      apply_stimulus(1'b0, k);
      hold_cycles(2);
    end
    apply_stimulus(1'b1, k);
    expect_event(EV_PRESS, k + LAT);
    hold_cycles(20);
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1'b0, k);
      hold_cycles(7);
      apply_stimulus(1'b1, k);
      hold_cycles(5);
      check_state("glitch_kept_pressed", 1);
    end
    apply_stimulus(1'b0, k);
    expect_event(EV_RELEASE, k + LAT);
    hold_cycles(20);
    check_drained("bounce");

    // Threshold: a 7-cycle low is ignored, an 8-cycle low is a real release
    // followed by a fresh press once the line returns high.
    $display("[TB] glitch threshold");
    apply_stimulus(1'b1, k);
    expect_event(EV_PRESS, k + LAT);
    hold_cycles(20);
    apply_stimulus(1'b0, k);
    hold_cycles(7);
    apply_stimulus(1'b1, k);
    hold_cycles(10);
    check_state("threshold_short_low", 1);
    apply_stimulus(1'b0, k);
    expect_event(EV_RELEASE, k + LAT);
    hold_cycles(8);
    apply_stimulus(1'b1, k);
    expect_event(EV_PRESS, k + LAT);
    hold_cycles(20);
    apply_stimulus(1'b0, k);
    expect_event(EV_RELEASE, k + LAT);
    hold_cycles(20);
    check_drained("threshold");

    // Long hold: one b_hold HOLD cycles after the press, never repeated,
    // not even after a rejected release glitch.
    $display("[TB] long hold");
    apply_stimulus(1'b1, k);
    expect_event(EV_PRESS, k + LAT);
    expect_event(EV_HOLD, k + LAT + HOLD);
    hold_cycles(100);
    apply_stimulus(1'b0, k);
    hold_cycles(7);
    apply_stimulus(1'b1, k);
    hold_cycles(60);
    check_state("hold_still_pressed", 1);
    apply_stimulus(1'b0, k);
    expect_event(EV_RELEASE, k + LAT);
    hold_cycles(20);
    check_drained("long_hold");

    // Reset while pressed: outputs clear with no release pulse; the still
    // held button is requalified from scratch after reset.
    $display("[TB] reset mid-press");
    apply_stimulus(1'b1, k);
    expect_event(EV_PRESS, k + LAT);
    hold_cycles(15);
    check_state("before_reset", 1);
    rst = 1'b0;
    hold_cycles(1);
    check_idle_outputs("mid_press_reset");
    hold_cycles(2);
    rst = 1'b1;
    k = edge_n + 1;
    expect_event(EV_PRESS, k + LAT);
    hold_cycles(LAT - 1);
    check_state("requalifying", 0);
    hold_cycles(11);
    check_state("after_reset_pressed", 1);
    apply_stimulus(1'b0, k);
    expect_event(EV_RELEASE, k + LAT);
    hold_cycles(20);
    check_drained("reset_mid_press");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
